// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store sequencer: op encoding, FSM states, byte-enable masks.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
//
// N_REG / N_REG_ADDR normally come from the project-wide defines.svh. They are
// guarded here so this slice also builds stand-alone.
`ifndef N_REG
`define N_REG 32
`endif
`ifndef N_REG_ADDR
`define N_REG_ADDR 5
`endif

package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Lane-0 byte-enable masks; shifted up by the lane offset in the aligner.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane alignment for loads/stores: byte enables, store-data replication, load extract/extend.
// Latency: purely combinational (0 cycles).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   op_i          memory op (mem_op_e)
//   addr_lo_i     low two bits of the effective address
//   store_data_i  rt value for stores
//   rdata_i       bus read word
//   be_o          byte enables
//   wdata_o       lane-replicated store data
//   load_result_o sign/zero-extended load value
//   misaligned_o  halfword on odd address, or word not on a 4-byte boundary
module mem_lsu_align
    import mem_pkg::*;
(
    input  mem_op_e              op_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [`N_REG-1:0]    store_data_i,
    input  logic [`N_REG-1:0]    rdata_i,
    output logic [3:0]           be_o,
    output logic [`N_REG-1:0]    wdata_o,
    output logic [`N_REG-1:0]    load_result_o,
    output logic                 misaligned_o
);

    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane is the address low bits with the sub-size bits forced to zero, so a
    // misaligned halfword/word simply lands on its natural boundary.
    always_comb begin
        misaligned_o = 1'b0;
        lane         = addr_lo_i;
        unique case (op_i)
            MEM_LH, MEM_LHU, MEM_SH: begin
                misaligned_o = addr_lo_i[0];
                lane         = {addr_lo_i[1], 1'b0};
            end
            MEM_LW, MEM_SW: begin
                misaligned_o = |addr_lo_i;
                lane         = 2'b00;
            end
            default: ;
        endcase
    end

    assign byte_sel = rdata_i[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o          = 4'b0000;
        wdata_o       = '0;
        load_result_o = '0;
        unique case (op_i)
            MEM_LB: begin
                be_o          = BE_BYTE << lane;
                load_result_o = {{(`N_REG-8){byte_sel[7]}}, byte_sel};
            end
            MEM_LBU: begin
                be_o          = BE_BYTE << lane;
                load_result_o = {{(`N_REG-8){1'b0}}, byte_sel};
            end
            MEM_LH: begin
                be_o          = BE_HALF << lane;
                load_result_o = {{(`N_REG-16){half_sel[15]}}, half_sel};
            end
            MEM_LHU: begin
                be_o          = BE_HALF << lane;
                load_result_o = {{(`N_REG-16){1'b0}}, half_sel};
            end
            MEM_LW: begin
                be_o          = BE_WORD;
                load_result_o = rdata_i;
            end
            MEM_SB: begin
                be_o    = BE_BYTE << lane;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEM_SH: begin
                be_o    = BE_HALF << lane;
                wdata_o = {2{store_data_i[15:0]}};
            end
            MEM_SW: begin
                be_o    = BE_WORD;
                wdata_o = store_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer over a req/ack data bus; forwards GPR writeback to MEM/WB.
// Latency: non-memory ops 0 cycles; memory ops >= 3 cycles (IDLE, BUSY..ack, DONE).
// Backpressure: o_stall_req holds the pipeline from request until DONE; bus waits on i_bus_ack.
//
// Optional feature macro: MEM_ALIGN_EXC_EN -- adds o_align_exc and suppresses
// misaligned accesses; without it, misaligned low address bits are ignored.
//
// Ports:
//   i_clk/i_rst                 clock, synchronous active-high reset
//   i_valid/i_mem_op/i_addr     MEM-stage instruction and effective address
//   i_store_data                rt value for stores
//   i_wen/i_waddr/i_wdata       writeback fields from EX
//   o_wen/o_waddr/o_wdata       writeback fields to MEM/WB
//   o_stall_req                 pipeline stall request
//   o_bus_*/i_bus_ack/rdata     registered data-bus request and its response
//   o_bus_timeout               one-cycle pulse when an access is aborted
//   o_align_exc                 misaligned-access flag (MEM_ALIGN_EXC_EN only)
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [3:0]               i_mem_op,
    input  logic [`N_REG-1:0]        i_addr,
    input  logic [`N_REG-1:0]        i_store_data,
    input  logic                     i_wen,
    input  logic [`N_REG_ADDR-1:0]   i_waddr,
    input  logic [`N_REG-1:0]        i_wdata,
    output logic                     o_wen,
    output logic [`N_REG_ADDR-1:0]   o_waddr,
    output logic [`N_REG-1:0]        o_wdata,
    output logic                     o_stall_req,
    output logic                     o_bus_req,
    output logic                     o_bus_we,
    output logic [`N_REG-1:0]        o_bus_addr,
    output logic [3:0]               o_bus_be,
    output logic [`N_REG-1:0]        o_bus_wdata,
    input  logic                     i_bus_ack,
    input  logic [`N_REG-1:0]        i_bus_rdata,
    output logic                     o_bus_timeout
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic                     o_align_exc
`endif
);

    localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

    mem_op_e           op_in;
    logic              mem_op_present;
    logic              mem_req;
    logic              misaligned;

    fsm_state_e        state_q;
    mem_op_e           op_q;
    logic [1:0]        addr_lo_q;
    logic [`N_REG-1:0] load_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [`N_REG-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [`N_REG-1:0] bus_wdata_q;
    logic              bus_timeout_q;

    mem_op_e           al_op;
    logic [1:0]        al_addr_lo;
    logic [3:0]        al_be;
    logic [`N_REG-1:0] al_wdata;
    logic [`N_REG-1:0] al_load;

    assign op_in          = mem_op_e'(i_mem_op);
    assign mem_op_present = i_valid && (op_in != MEM_NONE);

`ifdef MEM_ALIGN_EXC_EN
    assign mem_req     = mem_op_present && !misaligned;
    assign o_align_exc = mem_op_present && misaligned && (state_q == ST_IDLE);
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign mem_req           = mem_op_present;
`endif

    // One aligner serves both phases: in IDLE it shapes the outgoing request
    // from the live inputs; afterwards it extracts the load from the latched op.
    assign al_op      = (state_q == ST_IDLE) ? op_in : op_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? i_addr[1:0] : addr_lo_q;

    mem_lsu_align u_align (
        .op_i          (al_op),
        .addr_lo_i     (al_addr_lo),
        .store_data_i  (i_store_data),
        .rdata_i       (i_bus_rdata),
        .be_o          (al_be),
        .wdata_o       (al_wdata),
        .load_result_o (al_load),
        .misaligned_o  (misaligned)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            op_q          <= MEM_NONE;
            addr_lo_q     <= 2'b00;
            load_q        <= '0;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bus_timeout_q <= 1'b0;
                    if (mem_req) begin
                        state_q     <= ST_BUSY;
                        op_q        <= op_in;
                        addr_lo_q   <= i_addr[1:0];
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_store(op_in);
                        bus_addr_q  <= {i_addr[`N_REG-1:2], 2'b00};
                        bus_be_q    <= al_be;
                        bus_wdata_q <= al_wdata;
                    end
                end
                ST_BUSY: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (i_bus_ack) begin
                        load_q    <= al_load;
                        bus_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if ((BUS_TIMEOUT != 0) && (cnt_inc == CNT_W'(BUS_TIMEOUT))) begin
                            bus_req_q     <= 1'b0;
                            bus_timeout_q <= 1'b1;
                            state_q       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    bus_timeout_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Writeback mux. bus_timeout_q is high exactly during the DONE cycle of an
    // aborted access, so it doubles as the "suppress writeback" flag there.
    always_comb begin
        o_waddr     = i_waddr;
        o_wdata     = i_wdata;
        o_wen       = 1'b0;
        o_stall_req = 1'b0;
        if (!i_rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        o_stall_req = 1'b1;
                    end else if (!mem_op_present) begin
                        o_wen = i_wen;
                    end
                end
                ST_BUSY: begin
                    o_stall_req = 1'b1;
                end
                ST_DONE: begin
                    o_wen   = i_wen && !bus_timeout_q;
                    o_wdata = is_load(op_q) ? load_q : i_wdata;
                end
                default: ;
            endcase
        end
    end

    assign o_bus_req     = bus_req_q;
    assign o_bus_we      = bus_we_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_be      = bus_be_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] WD  = 32'h0000_5A5A;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_valid, i_wen, i_bus_ack;
    logic [3:0]  i_mem_op;
    logic [31:0] i_addr, i_store_data, i_wdata, i_bus_rdata;
    logic [4:0]  i_waddr;
    logic        o_wen, o_stall_req, o_bus_req, o_bus_we, o_bus_timeout;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
`ifdef MEM_ALIGN_EXC_EN
    logic        o_align_exc;
`endif

    mem_access_ctrl #(.BUS_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_op(i_mem_op),
        .i_addr(i_addr), .i_store_data(i_store_data), .i_wen(i_wen),
        .i_waddr(i_waddr), .i_wdata(i_wdata), .o_wen(o_wen), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_stall_req(o_stall_req), .o_bus_req(o_bus_req),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_bus_timeout(o_bus_timeout)
`ifdef MEM_ALIGN_EXC_EN
        , .o_align_exc(o_align_exc)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;
    int stall_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sd, input logic wen);
        i_valid      = 1'b1;
        i_mem_op     = op;
        i_addr       = addr;
        i_store_data = sd;
        i_wen        = wen;
        i_wdata      = WD;
    endtask

    task automatic set_idle();
        i_valid   = 1'b0;
        i_mem_op  = MEM_NONE;
        i_wen     = 1'b0;
        i_bus_ack = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //           op       addr          sd             rdata          wen   be       bus wdata      o_wdata
        vecs[0] = '{MEM_LB,  32'h0000_0103, 32'h0,         32'h8000_0000, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[1] = '{MEM_LBU, 32'h0000_0101, 32'h0,         32'h0000_A500, 1'b1, 4'b0010, 32'h0,         32'h0000_00A5};
        vecs[2] = '{MEM_LH,  32'h0000_0102, 32'h0,         32'h8001_1234, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[3] = '{MEM_LHU, 32'h0000_0100, 32'h0,         32'h8001_F00D, 1'b1, 4'b0011, 32'h0,         32'h0000_F00D};
        vecs[4] = '{MEM_LW,  32'h0000_0204, 32'h0,         32'hCAFE_BABE, 1'b1, 4'b1111, 32'h0,         32'hCAFE_BABE};
        vecs[5] = '{MEM_SB,  32'h0000_0302, 32'h1122_33C4, 32'h0,         1'b0, 4'b0100, 32'hC4C4_C4C4, WD};
        vecs[6] = '{MEM_SW,  32'h0000_0308, 32'h0BAD_F00D, 32'h0,         1'b0, 4'b1111, 32'h0BAD_F00D, WD};
        vecs[7] = '{MEM_LB,  32'h0000_0300, 32'h0,         32'h1234_567F, 1'b1, 4'b0001, 32'h0,         32'h0000_007F};

        // Reset: hold a would-be load on the inputs to show the gating.
        i_rst = 1'b1;
        set_instr(MEM_LW, 32'h40, 32'h0, 1'b1);
        i_waddr = 5'd3; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
        next_cycle();
        @(negedge clk);
        chk("rst_stall",   {31'b0, o_stall_req},   32'h0);
        chk("rst_wen",     {31'b0, o_wen},         32'h0);
        chk("rst_bus_req", {31'b0, o_bus_req},     32'h0);
        chk("rst_tmo",     {31'b0, o_bus_timeout}, 32'h0);
        chk("rst_bus_be",  {28'b0, o_bus_be},      32'h0);
        chk("rst_bus_addr", o_bus_addr,            32'h0);

        // ALU op passes straight through.
        next_cycle();
        i_rst = 1'b0;
        set_instr(MEM_NONE, 32'h0, 32'h0, 1'b1);
        i_wdata = 32'h1234; i_waddr = 5'd7;
        @(negedge clk);
        chk("alu_wen",   {31'b0, o_wen},       32'h1);
        chk("alu_wdata", o_wdata,              32'h1234);
        chk("alu_stall", {31'b0, o_stall_req}, 32'h0);
        chk("alu_waddr", {27'b0, o_waddr},     32'h7);

        // Table: single-beat accesses, ack in the first BUSY cycle.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            set_instr(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].wen);
            i_waddr = 5'(i + 1);
            @(negedge clk);
            chk("v_idle_stall", {31'b0, o_stall_req}, 32'h1);
            chk("v_idle_wen",   {31'b0, o_wen},       32'h0);
            next_cycle();
            i_bus_ack = 1'b1; i_bus_rdata = vecs[i].rdata;
            @(negedge clk);
            chk("v_busy_req",  {31'b0, o_bus_req},   32'h1);
            chk("v_busy_be",   {28'b0, o_bus_be},    {28'b0, vecs[i].be});
            chk("v_busy_addr", o_bus_addr,           {vecs[i].addr[31:2], 2'b00});
            chk("v_busy_we",   {31'b0, o_bus_we},    {31'b0, !vecs[i].wen});
            chk("v_busy_stall", {31'b0, o_stall_req}, 32'h1);
            if (!vecs[i].wen) chk("v_busy_wdata", o_bus_wdata, vecs[i].bwdata);
            next_cycle();
            i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
            @(negedge clk);
            chk("v_done_stall", {31'b0, o_stall_req}, 32'h0);
            chk("v_done_req",   {31'b0, o_bus_req},   32'h0);
            chk("v_done_wen",   {31'b0, o_wen},       {31'b0, vecs[i].wen});
            chk("v_done_wdata", o_wdata,              vecs[i].wdata);
            chk("v_done_waddr", {27'b0, o_waddr},     32'(i + 1));
        end

        // SH with ack in the third BUSY cycle: stall for 4 cycles.
        next_cycle();
        set_instr(MEM_SH, 32'h0000_0102, 32'hAAAA_BEEF, 1'b0);
        stall_cycles = 0;
        @(negedge clk);
        stall_cycles += int'(o_stall_req);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            i_bus_ack = (k == 2);
            @(negedge clk);
            stall_cycles += int'(o_stall_req);
            chk("sh_req",   {31'b0, o_bus_req}, 32'h1);
            chk("sh_we",    {31'b0, o_bus_we},  32'h1);
            chk("sh_be",    {28'b0, o_bus_be},  32'hC);
            chk("sh_wdata", o_bus_wdata,        32'hBEEF_BEEF);
        end
        next_cycle();
        i_bus_ack = 1'b0;
        @(negedge clk);
        stall_cycles += int'(o_stall_req);
        chk("sh_stall_cycles", 32'(stall_cycles), 32'd4);

        // LW never acked: aborts after TMO BUSY cycles.
        next_cycle();
        set_instr(MEM_LW, 32'h0000_0400, 32'h0, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            chk("tmo_busy_req", {31'b0, o_bus_req},     32'h1);
            chk("tmo_busy_tmo", {31'b0, o_bus_timeout}, 32'h0);
        end
        next_cycle();
        @(negedge clk);
        chk("tmo_pulse",      {31'b0, o_bus_timeout}, 32'h1);
        chk("tmo_done_req",   {31'b0, o_bus_req},     32'h0);
        chk("tmo_done_wen",   {31'b0, o_wen},         32'h0);
        chk("tmo_done_stall", {31'b0, o_stall_req},   32'h0);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("tmo_after_pulse", {31'b0, o_bus_timeout}, 32'h0);
        chk("tmo_after_stall", {31'b0, o_stall_req},   32'h0);

        // Ack arriving in the same cycle the timeout would fire: ack wins.
        next_cycle();
        set_instr(MEM_LW, 32'h0000_0404, 32'h0, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            i_bus_ack = (k == 3); i_bus_rdata = 32'h1357_9BDF;
            @(negedge clk);
        end
        next_cycle();
        i_bus_ack = 1'b0;
        @(negedge clk);
        chk("race_tmo",   {31'b0, o_bus_timeout}, 32'h0);
        chk("race_wen",   {31'b0, o_wen},         32'h1);
        chk("race_wdata", o_wdata,                32'h1357_9BDF);

        // Reset in the second BUSY cycle of an LHU abandons the access.
        next_cycle();
        set_instr(MEM_LHU, 32'h0000_0500, 32'h0, 1'b1);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("rstb_busy_req", {31'b0, o_bus_req}, 32'h1);
        next_cycle();
        i_rst = 1'b1;
        @(negedge clk);
        chk("rstb_stall", {31'b0, o_stall_req}, 32'h0);
        chk("rstb_wen",   {31'b0, o_wen},       32'h0);
        next_cycle();
        i_rst = 1'b0;
        set_instr(MEM_NONE, 32'h0, 32'h0, 1'b1);
        i_wdata = 32'h77;
        @(negedge clk);
        chk("rstb_after_req",   {31'b0, o_bus_req},   32'h0);
        chk("rstb_after_stall", {31'b0, o_stall_req}, 32'h0);
        chk("rstb_after_wen",   {31'b0, o_wen},       32'h1);
        chk("rstb_after_wdata", o_wdata,              32'h77);

        // Misaligned LW at 0x101.
        next_cycle();
        set_instr(MEM_LW, 32'h0000_0101, 32'h0, 1'b1);
`ifdef MEM_ALIGN_EXC_EN
        @(negedge clk);
        chk("mis_exc",   {31'b0, o_align_exc}, 32'h1);
        chk("mis_stall", {31'b0, o_stall_req}, 32'h0);
        chk("mis_wen",   {31'b0, o_wen},       32'h0);
        next_cycle();
        @(negedge clk);
        chk("mis_req",   {31'b0, o_bus_req},   32'h0);
        chk("mis_exc2",  {31'b0, o_align_exc}, 32'h1);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("mis_exc_clr", {31'b0, o_align_exc}, 32'h0);
`else
        @(negedge clk);
        chk("mis_stall", {31'b0, o_stall_req}, 32'h1);
        next_cycle();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h2468_1357;
        @(negedge clk);
        chk("mis_addr", o_bus_addr,         32'h0000_0100);
        chk("mis_be",   {28'b0, o_bus_be},  32'hF);
        next_cycle();
        i_bus_ack = 1'b0;
        @(negedge clk);
        chk("mis_wdata", o_wdata,       32'h2468_1357);
        chk("mis_wen",   {31'b0, o_wen}, 32'h1);
`endif

        next_cycle();
        set_idle();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
